gameboy_lcd_sampler: RTL and testbench
======================================

// Module: gameboy_lcd_sampler
// PURPOSE
//  Front end of the LCD capture path; feeds gameboy_lcd_decoder.
//  Synchronises the raw Game Boy LCD pins (CP, HSYNC, VSYNC, LD0/LD1) into the system clock domain.
//  Detects pixel, line and frame events, and emits one-cycle strobes with 2-bit pixel data and x/y coordinates.
//  Provides a framing watchdog and sticky error flags.
// PARAMETERS
//  SYNC_STAGES    2       flops per raw input synchroniser (>=2)
//  H_PIXELS       160     pixels per line
//  V_LINES        144     lines per frame
//  TIMEOUT_CYCLES 65535   clock cycles without a CP falling edge before the watchdog trips
//  CNT_WIDTH      8       width of pixel_x/pixel_y
// PORTS
//  clock        in   1          system clock; all logic on its rising edge
//  reset        in   1          asynchronous, active-high
//  pixel_clock  in   1          raw LCD CP, asynchronous to clock
//  h_sync       in   1          raw LCD HSYNC (line latch), asynchronous
//  v_sync       in   1          raw LCD VSYNC (frame start), asynchronous
//  lcd_data0    in   1          raw LD0, asynchronous
//  lcd_data1    in   1          raw LD1, asynchronous
//  pixel_valid  out  1          one-cycle strobe: pixel_data, pixel_x and pixel_y are valid
//  pixel_data   out  2          {LD1,LD0} sampled at CP falling edge
//  pixel_x      out  CNT_WIDTH  column of current pixel, 0..H_PIXELS-1
//  pixel_y      out  CNT_WIDTH  row of current pixel, 0..V_LINES-1
//  line_start   out  1          one-cycle strobe on accepted HSYNC rise
//  frame_start  out  1          one-cycle strobe on VSYNC rise
//  frame_done   out  1          one-cycle strobe, same cycle as pixel (H_PIXELS-1, V_LINES-1)
//  overrun      out  1          sticky: extra pixel or line beyond limits; cleared on frame_start
//  timeout      out  1          sticky: watchdog tripped; cleared on frame_start
// BEHAVIOUR
//  Reset: all sync flops 0, state IDLE, counters 0, every output 0. Reset mid-frame aborts capture.
//  Sync: each raw pin goes through SYNC_STAGES flops, then one history flop.
//   Events: cp_fall = hist&~sync; hs_rise and vs_rise = ~hist&sync.
//   Latency from raw edge to strobe: SYNC_STAGES+1 cycles.
//   Data flops share stage count with CP, so data is sampled with CP's edge.
//  FSM states: IDLE, WAIT_LINE, ACTIVE.
//   IDLE: ignores cp_fall and hs_rise. vs_rise -> WAIT_LINE, y=0, first_line=1, frame_start.
//   WAIT_LINE: hs_rise -> ACTIVE, x=0, line_start. cp_fall is ignored.
//   ACTIVE: cp_fall with x<H_PIXELS -> pixel_valid with current x,y, then x+1.
//    cp_fall with x==H_PIXELS -> set overrun, drop the pixel.
//   ACTIVE hs_rise: x=0, line_start.
//    y unchanged if first_line (then clear first_line); otherwise y+1.
//    If y==V_LINES-1 (not first line): set overrun, go to IDLE, no line_start.
//   vs_rise in WAIT_LINE or ACTIVE: restart frame exactly as from IDLE.
//  Simultaneous events in one cycle, priority vs > hs > cp:
//   vs+hs: frame_start and line_start together, state ACTIVE, x=0, y=0, first_line cleared.
//   hs+cp in ACTIVE: line update first; pixel emitted as x=0 of the new line.
//   vs+cp: pixel dropped.
//  frame_done: same cycle as pixel_valid for x=H_PIXELS-1, y=V_LINES-1. State -> IDLE.
//  Watchdog:
//   Counter runs in WAIT_LINE and ACTIVE; cleared by cp_fall, hs_rise and vs_rise; saturates.
//   Reaching TIMEOUT_CYCLES sets timeout and forces IDLE.
//  Registered outputs: pixel_data, pixel_x and pixel_y hold their value between strobes.
//  Strobes are never longer than one cycle.
// TESTING
//  Reset held, pins toggling -> all outputs 0. Release; first vs_rise -> frame_start after SYNC_STAGES+1 cycles.
//  VSYNC, then 144 x (HSYNC + 160 CP falls, data pattern x[1:0]):
//   -> 23040 pixel_valid, last at (159,143) with frame_done; pixel_data matches the pattern.
//  161 CP falls in a line -> 160 pixel_valid, overrun=1.
//   Next frame_start clears overrun.
//  HSYNC and VSYNC rise on the same clock:
//   -> frame_start and line_start in one cycle; next pixel at (0,0).
//  CP stops mid-line for TIMEOUT_CYCLES -> timeout=1, state IDLE.
//   Later CP and HSYNC edges give no strobes until VSYNC.
//  Reset asserted at (80,70) -> immediate zeroing of outputs.
//   After release, pixels are ignored until VSYNC.

Source files
------------

// File: rtl/gameboy_lcd_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gameboy_lcd_sampler : synchronises raw Game Boy LCD pins and emits
//                       pixel/line/frame strobes with x/y coordinates.
// Revision 1.0
// ============================================================================
module gameboy_lcd_sampler #(
  parameter int SYNC_STAGES    = 2,
  parameter int H_PIXELS       = 160,
  parameter int V_LINES        = 144,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pixel_clock,
  input  logic                 h_sync,
  input  logic                 v_sync,
  input  logic                 lcd_data0,
  input  logic                 lcd_data1,
  output logic                 pixel_valid,
  output logic [1:0]           pixel_data,
  output logic [CNT_WIDTH-1:0] pixel_x,
  output logic [CNT_WIDTH-1:0] pixel_y,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 timeout
);

  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] c_idle      = 2'd0;
  localparam logic [1:0] c_wait_line = 2'd1;
  localparam logic [1:0] c_active    = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_h      = CNT_WIDTH'(H_PIXELS);
  localparam logic [CNT_WIDTH-1:0] c_h_last = CNT_WIDTH'(H_PIXELS - 1);
  localparam logic [CNT_WIDTH-1:0] c_y_last = CNT_WIDTH'(V_LINES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
  localparam logic [WD_WIDTH-1:0]  c_wd_max  = WD_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0]  c_wd_trip = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_WIDTH-1:0]  c_wd_one  = WD_WIDTH'(1);

  logic [4:0]           w_raw;
  logic [4:0]           r_sync [SYNC_STAGES];
  logic [4:0]           w_sync;
  logic [2:0]           r_hist;
  logic                 w_cp_fall, w_hs_rise, w_vs_rise, w_any_event;

  logic [1:0]           r_state, w_state_next;
  logic [CNT_WIDTH-1:0] r_x, r_y, w_x_eff, w_y_eff;
  logic                 r_first_line, w_first_next;
  logic [WD_WIDTH-1:0]  r_wd;
  logic                 w_frame, w_line, w_line_over, w_pix, w_pix_over, w_done, w_wd_trip;

  // Data pins ride the same pipeline as CP so they line up with its falling edge.
  assign w_raw = {lcd_data1, lcd_data0, v_sync, h_sync, pixel_clock};
  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_sync[2:0];
    end
  end

  assign w_cp_fall   = r_hist[0] & ~w_sync[0];
  assign w_hs_rise   = ~r_hist[1] & w_sync[1];
  assign w_vs_rise   = ~r_hist[2] & w_sync[2];
  assign w_any_event = w_cp_fall | w_hs_rise | w_vs_rise;
  assign w_wd_trip   = (r_state != c_idle) && !w_any_event && (r_wd == c_wd_trip);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_frame) begin
      w_state_next = w_line ? c_active : c_wait_line;
    end else if (r_state != c_idle) begin
      if (w_wd_trip || w_line_over || w_done) w_state_next = c_idle;
      else if (w_line)                        w_state_next = c_active;
    end
  end

  // Event resolution, priority vsync > hsync > pixel clock.
  always_comb begin
    w_frame      = 1'b0;
    w_line       = 1'b0;
    w_line_over  = 1'b0;
    w_pix        = 1'b0;
    w_pix_over   = 1'b0;
    w_done       = 1'b0;
    w_x_eff      = r_x;
    w_y_eff      = r_y;
    w_first_next = r_first_line;
    if (w_vs_rise) begin
      w_frame      = 1'b1;
      w_y_eff      = '0;
      w_first_next = 1'b1;
      if (w_hs_rise) begin
        w_line       = 1'b1;
        w_x_eff      = '0;
        w_first_next = 1'b0;
      end
    end else if (r_state != c_idle) begin
      if (w_hs_rise) begin
        if (r_first_line) begin
          w_line       = 1'b1;
          w_x_eff      = '0;
          w_first_next = 1'b0;
        end else if (r_y == c_y_last) begin
          w_line_over = 1'b1;
        end else begin
          w_line  = 1'b1;
          w_x_eff = '0;
          w_y_eff = r_y + c_cnt_one;
        end
      end
      if (w_cp_fall && (r_state == c_active) && !w_line_over) begin
        if (w_x_eff == c_h) begin
          w_pix_over = 1'b1;
        end else begin
          w_pix  = 1'b1;
          w_done = (w_x_eff == c_h_last) && (w_y_eff == c_y_last);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_first_line <= 1'b0;
      r_wd         <= '0;
      pixel_valid  <= 1'b0;
      pixel_data   <= '0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_x          <= w_pix ? (w_x_eff + c_cnt_one) : w_x_eff;
      r_y          <= w_y_eff;
      r_first_line <= w_first_next;
      pixel_valid  <= w_pix;
      line_start   <= w_line;
      frame_start  <= w_frame;
      frame_done   <= w_done;
      if (w_pix) begin
        pixel_data <= w_sync[4:3];
        pixel_x    <= w_x_eff;
        pixel_y    <= w_y_eff;
      end
      if (w_frame)                        overrun <= 1'b0;
      else if (w_pix_over || w_line_over) overrun <= 1'b1;
      if (w_frame)        timeout <= 1'b0;
      else if (w_wd_trip) timeout <= 1'b1;
      if (w_any_event || (r_state == c_idle)) r_wd <= '0;
      else if (r_wd != c_wd_max)              r_wd <= r_wd + c_wd_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gameboy_lcd_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_gameboy_lcd_sampler : table vectors, directed frames and random lines
//                          checked against a line/column reference model.
// Revision 1.0
// ============================================================================
module tb_gameboy_lcd_sampler;

  localparam int SYNC = 2;
  localparam int H    = 160;
  localparam int V    = 144;
  localparam int TO   = 300;

  logic       clock = 1'b0, reset = 1'b1;
  logic       pixel_clock = 1'b1, h_sync = 1'b0, v_sync = 1'b0, lcd_data0 = 1'b0, lcd_data1 = 1'b0;
  logic       pixel_valid, line_start, frame_start, frame_done, overrun, timeout;
  logic [1:0] pixel_data;
  logic [7:0] pixel_x, pixel_y;

  gameboy_lcd_sampler #(
    .SYNC_STAGES(SYNC), .H_PIXELS(H), .V_LINES(V), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .pixel_clock(pixel_clock), .h_sync(h_sync), .v_sync(v_sync),
    .lcd_data0(lcd_data0), .lcd_data1(lcd_data1), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y), .line_start(line_start),
    .frame_start(frame_start), .frame_done(frame_done), .overrun(overrun), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fs, ls, pv, fd;
    logic [7:0] x, y;
    logic [1:0] pd;
  } rec_t;

  typedef struct {
    logic       vs, hs, cp;
    logic [1:0] d;
    rec_t       exp;
  } vec_t;

  int   n_vec = 0, n_bad = 0, pv_count = 0;
  bit   mon_en = 1'b0;
  rec_t exp_q[$];

  // Reference model: row -1 means a frame is open but no line has begun.
  bit m_armed, m_over, m_tout;
  int m_row, m_col;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_op(input bit vs, input bit hs, input bit cp, input bit [1:0] d);
    rec_t r;
    bit   was_active;
    r = '{fs: 1'b0, ls: 1'b0, pv: 1'b0, fd: 1'b0, x: 8'd0, y: 8'd0, pd: 2'd0};
    was_active = m_armed && (m_row >= 0);
    if (vs) begin
      m_armed = 1'b1; m_row = -1; m_over = 1'b0; m_tout = 1'b0; r.fs = 1'b1;
      if (hs) begin m_row = 0; m_col = 0; r.ls = 1'b1; end
    end else if (m_armed) begin
      if (hs) begin
        if (m_row == V - 1) begin m_over = 1'b1; m_armed = 1'b0; end
        else begin m_row++; m_col = 0; r.ls = 1'b1; end
      end
      if (cp && was_active && m_armed) begin
        if (m_col >= H) m_over = 1'b1;
        else begin
          r.pv = 1'b1; r.x = 8'(m_col); r.y = 8'(m_row); r.pd = d;
          if (m_col == H - 1 && m_row == V - 1) begin r.fd = 1'b1; m_armed = 1'b0; end
          m_col++;
        end
      end
    end
    if (r.fs || r.ls || r.pv) exp_q.push_back(r);
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_over = 1'b0; m_tout = 1'b0; m_row = -1; m_col = 0;
    exp_q.delete();
  endtask

  // One event pulse: pins active for one cycle, then one idle cycle.
  task automatic pulse(input bit vs, input bit hs, input bit cp, input bit [1:0] d);
    if (mon_en) model_op(vs, hs, cp, d);
    @(negedge clock);
    v_sync = vs; h_sync = hs; pixel_clock = ~cp; {lcd_data1, lcd_data0} = d;
    @(negedge clock);
    v_sync = 1'b0; h_sync = 1'b0; pixel_clock = 1'b1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    repeat (SYNC + 4) @(negedge clock);
    while (exp_q.size() != 0 && k < 50) begin @(negedge clock); k++; end
    check({name, " pending strobes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic vec_t mk(input bit vs, hs, cp, input bit [1:0] d,
                              input bit fs, ls, pv, input int x, y, input bit [1:0] pd);
    vec_t v;
    v.vs = vs; v.hs = hs; v.cp = cp; v.d = d;
    v.exp = '{fs: fs, ls: ls, pv: pv, fd: 1'b0, x: 8'(x), y: 8'(y), pd: pd};
    return v;
  endfunction

  always @(negedge clock) begin
    rec_t e;
    if (mon_en && (frame_start || line_start || pixel_valid || frame_done)) begin
      if (pixel_valid) pv_count++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected strobe: got fs/ls/pv/fd=%b%b%b%b x=%0d y=%0d, expected none",
                 frame_start, line_start, pixel_valid, frame_done, pixel_x, pixel_y);
      end else begin
        e = exp_q.pop_front();
        if ({frame_start, line_start, pixel_valid, frame_done} !== {e.fs, e.ls, e.pv, e.fd} ||
            (e.pv && ({pixel_x, pixel_y, pixel_data} !== {e.x, e.y, e.pd}))) begin
          n_bad++;
          $display("FAIL strobe: got fs/ls/pv/fd=%b%b%b%b x=%0d y=%0d d=%0d, expected %b%b%b%b x=%0d y=%0d d=%0d",
                   frame_start, line_start, pixel_valid, frame_done, pixel_x, pixel_y, pixel_data,
                   e.fs, e.ls, e.pv, e.fd, e.x, e.y, e.pd);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    n_bad++;
    $display("FAIL global time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "time limit");
  end

  initial begin
    vec_t       tbl [12];
    logic [17:0] held;
    logic [17:0] act_hold;

    tbl[0]  = mk(1, 0, 0, 2'd0, 1, 0, 0, 0, 0, 2'd0);
    tbl[1]  = mk(0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0);
    tbl[2]  = mk(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0);
    tbl[3]  = mk(0, 0, 1, 2'd1, 0, 0, 1, 0, 0, 2'd1);
    tbl[4]  = mk(0, 0, 1, 2'd3, 0, 0, 1, 1, 0, 2'd3);
    tbl[5]  = mk(0, 1, 1, 2'd2, 0, 1, 1, 0, 1, 2'd2);
    tbl[6]  = mk(1, 0, 1, 2'd1, 1, 0, 0, 0, 0, 2'd0);
    tbl[7]  = mk(1, 1, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0);
    tbl[8]  = mk(0, 0, 1, 2'd0, 0, 0, 1, 0, 0, 2'd0);
    tbl[9]  = mk(0, 1, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0);
    tbl[10] = mk(0, 0, 1, 2'd3, 0, 0, 1, 0, 1, 2'd3);
    tbl[11] = mk(0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);

    // Reset held while the pins toggle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("reset outputs", int'({pixel_valid, pixel_data, pixel_x, pixel_y, line_start,
                                   frame_start, frame_done, overrun, timeout}), 0);
      {pixel_clock, h_sync, v_sync, lcd_data0, lcd_data1} = 5'($urandom_range(0, 31));
    end
    pixel_clock = 1'b1; h_sync = 1'b0; v_sync = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Table vectors: exact sync latency and one-cycle strobe width.
    held = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      v_sync = tbl[i].vs; h_sync = tbl[i].hs; pixel_clock = ~tbl[i].cp;
      {lcd_data1, lcd_data0} = tbl[i].d;
      @(negedge clock);
      v_sync = 1'b0; h_sync = 1'b0; pixel_clock = 1'b1;
      repeat (SYNC) @(negedge clock);
      check($sformatf("tbl%0d strobes", i), int'({frame_start, line_start, pixel_valid, frame_done}),
            int'({tbl[i].exp.fs, tbl[i].exp.ls, tbl[i].exp.pv, tbl[i].exp.fd}));
      if (tbl[i].exp.pv) begin
        held = {tbl[i].exp.x, tbl[i].exp.y, tbl[i].exp.pd};
        check($sformatf("tbl%0d pixel", i), int'({pixel_x, pixel_y, pixel_data}), int'(held));
      end
      @(negedge clock);
      check($sformatf("tbl%0d strobes cleared", i),
            int'({frame_start, line_start, pixel_valid, frame_done}), 0);
      act_hold = {pixel_x, pixel_y, pixel_data};
      check($sformatf("tbl%0d pixel held", i), int'(act_hold), int'(held));
    end

    // Full frame with data pattern x[1:0].
    model_reset();
    mon_en = 1'b1;
    pv_count = 0;
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    for (int l = 0; l < V; l++) begin
      pulse(1'b0, 1'b1, 1'b0, 2'd0);
      for (int x = 0; x < H; x++) pulse(1'b0, 1'b0, 1'b1, 2'(x));
    end
    drain("full frame");
    check("full frame pixel count", pv_count, H * V);
    check("full frame overrun", int'(overrun), 0);

    // One CP fall too many in a line.
    pv_count = 0;
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    for (int x = 0; x <= H; x++) pulse(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    drain("pixel overrun");
    check("pixel overrun count", pv_count, H);
    check("pixel overrun flag", int'(overrun), 1);
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    drain("overrun clear");
    check("overrun cleared by frame", int'(overrun), 0);

    // One HSYNC too many in a frame: overrun, then capture stops.
    for (int l = 0; l <= V; l++) pulse(1'b0, 1'b1, 1'b0, 2'd0);
    pulse(1'b0, 1'b0, 1'b1, 2'd1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    drain("line overrun");
    check("line overrun flag", int'(overrun), 1);

    // Random lines near the pixel limit with stray sync events.
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    for (int l = 0; l < 24; l++) begin
      if ($urandom_range(0, 7) == 0)
        pulse(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else
        pulse(1'b0, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      for (int x = 0; x < int'($urandom_range(H - 2, H + 1)); x++) begin
        if ($urandom_range(0, 39) == 0)
          pulse(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        else
          pulse(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      end
    end
    drain("random");
    check("random overrun", int'(overrun), int'(m_over));
    check("random timeout", int'(timeout), int'(m_tout));

    // Watchdog: CP stalls mid-line.
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    for (int x = 0; x < 5; x++) pulse(1'b0, 1'b0, 1'b1, 2'(x));
    drain("pre timeout");
    repeat (TO - 40) @(negedge clock);
    check("timeout not yet", int'(timeout), 0);
    repeat (60) @(negedge clock);
    check("timeout set", int'(timeout), 1);
    m_armed = 1'b0; m_tout = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 2'd2);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    pulse(1'b0, 1'b0, 1'b1, 2'd3);
    drain("after timeout");
    check("timeout sticky", int'(timeout), 1);
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    drain("timeout clear");
    check("timeout cleared by frame", int'(timeout), 0);

    // Reset while at pixel (80,70).
    for (int l = 0; l <= 70; l++) pulse(1'b0, 1'b1, 1'b0, 2'd0);
    for (int x = 0; x <= 80; x++) pulse(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
    drain("to 80,70");
    check("position before reset", int'({pixel_x, pixel_y}), (80 << 8) | 70);
    #2 reset = 1'b1;
    #1 check("async reset outputs", int'({pixel_valid, pixel_data, pixel_x, pixel_y, line_start,
                                         frame_start, frame_done, overrun, timeout}), 0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    pulse(1'b0, 1'b0, 1'b1, 2'd1);
    pulse(1'b0, 1'b1, 1'b0, 2'd0);
    pulse(1'b0, 1'b0, 1'b1, 2'd2);
    drain("after reset");
    pulse(1'b1, 1'b0, 1'b0, 2'd0);
    drain("frame after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
